// File: rtl/seq_sub_pkg.sv
// Shared constants, mode encodings and FSM state type for the nibble-serial
// subtractor (seq_sub_unit and its helpers).
package seq_sub_pkg;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;

  localparam logic [1:0] LAST_NIB = 2'(NUM_NIB - 1);

  localparam logic MODE_SUB    = 1'b0;
  localparam logic MODE_PSUBSB = 1'b1;

  localparam logic [15:0] SAT_POS16 = 16'h7FFF;
  localparam logic [15:0] SAT_NEG16 = 16'h8000;
  localparam logic [3:0]  SAT_POS4  = 4'h7;
  localparam logic [3:0]  SAT_NEG4  = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_sub_if.sv
// Start/done request interface between decode (master) and the serial
// subtractor (slave).
//
// Handshake: start is a one-cycle request, taken only while the unit is idle
// (busy and done both low); A, B and mode are sampled on that same edge. busy
// stays high for the four nibble cycles, then done pulses for one cycle, and
// result/Z/N/V are valid from the done cycle until the next accepted start.
// A start seen while busy or done is dropped, never queued.
interface seq_sub_if;
  logic        start;
  logic        mode;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        Z;
  logic        N;
  logic        V;

  modport master (
    output start, mode, A, B,
    input  busy, done, result, Z, N, V
  );

  modport slave (
    input  start, mode, A, B,
    output busy, done, result, Z, N, V
  );
endinterface

// File: rtl/seq_sub_nib.sv
// One nibble of a - b as a + ~b + cin, with optional signed saturation of the
// nibble result (used for the packed per-nibble subtract).
module seq_sub_nib
  import seq_sub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  input  logic             sat,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0]   sum;
  logic [NIB_W-1:0] raw;
  logic             ovf;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, ~b} + {{NIB_W{1'b0}}, cin};
    raw  = sum[NIB_W-1:0];
    cout = sum[NIB_W];
    // Signed overflow: operands of opposite sign and the result sign left a's.
    ovf  = (a[NIB_W-1] != b[NIB_W-1]) && (raw[NIB_W-1] != a[NIB_W-1]);
    s    = raw;
    if (sat && ovf) begin
      s = a[NIB_W-1] ? SAT_NEG4 : SAT_POS4;
    end
  end

endmodule

// File: rtl/seq_sub_unit.sv
// Nibble-serial 16-bit subtractor: SUB (16-bit saturating) or PSUBSB (four
// 4-bit saturating lanes). Flag registers exist only with SEQ_SUB_FLAGS_EN.
module seq_sub_unit
  import seq_sub_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  seq_sub_if.slave bus,
  output state_t   dbg_state
);

  state_t           state_q;
  state_t           state_d;
  logic [15:0]      a_q;
  logic [15:0]      b_q;
  logic [15:0]      result_q;
  logic [15:0]      result_nxt;
  logic [15:0]      result_fin;
  logic             mode_q;
  logic             borrow_q;
  logic [1:0]       idx_q;
  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] nib_s;
  logic             nib_cin;
  logic             nib_sat;
  logic             nib_cout;
  logic             last_nib;
  logic             sub_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = BUSY;
      BUSY:    if (last_nib)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q == BUSY);
  assign bus.done  = (state_q == DONE);
  assign dbg_state = state_q;

  always_comb begin
    a_nib    = a_q[{idx_q, 2'b00} +: NIB_W];
    b_nib    = b_q[{idx_q, 2'b00} +: NIB_W];
    nib_cin  = (mode_q == MODE_SUB) ? borrow_q : 1'b1;
    nib_sat  = (mode_q == MODE_PSUBSB);
    last_nib = (idx_q == LAST_NIB);
    result_nxt = result_q;
    result_nxt[{idx_q, 2'b00} +: NIB_W] = nib_s;
    // Only meaningful on the last nibble, when result_nxt holds the raw difference.
    sub_ovf    = (mode_q == MODE_SUB) && (a_q[15] != b_q[15]) && (result_nxt[15] != a_q[15]);
    result_fin = sub_ovf ? (a_q[15] ? SAT_NEG16 : SAT_POS16) : result_nxt;
  end

  seq_sub_nib u_nib (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (nib_cin),
    .sat  (nib_sat),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // Saturation is folded into the last nibble's write so result is already
  // final in the cycle done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_SUB;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            mode_q   <= bus.mode;
            idx_q    <= '0;
            borrow_q <= 1'b1;
          end
        end
        BUSY: begin
          result_q <= last_nib ? result_fin : result_nxt;
          idx_q    <= idx_q + 2'd1;
          if (mode_q == MODE_SUB) borrow_q <= nib_cout;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;

`ifdef SEQ_SUB_FLAGS_EN
  logic z_q;
  logic n_q;
  logic v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else if (state_q == BUSY && last_nib) begin
      z_q <= (result_fin == 16'h0000);
      n_q <= (mode_q == MODE_SUB) && result_fin[15];
      v_q <= sub_ovf;
    end
  end

  assign bus.Z = z_q;
  assign bus.N = n_q;
  assign bus.V = v_q;
`else
  assign bus.Z = 1'b0;
  assign bus.N = 1'b0;
  assign bus.V = 1'b0;
`endif

endmodule

// File: tb/tb_seq_sub_unit.sv
// Bench for seq_sub_unit: directed cases plus randomized operations checked
// every cycle against an arithmetic reference model.
module tb_seq_sub_unit;
  import seq_sub_pkg::*;

`ifdef SEQ_SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     t_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_sub_if ifc ();

  seq_sub_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {Z, N, V, result} from plain signed arithmetic with clamping.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic m);
    logic [15:0] r;
    logic        z, n, v;
    int          d;
    r = '0;
    v = 1'b0;
    n = 1'b0;
    if (m == MODE_SUB) begin
      d = int'($signed(a)) - int'($signed(b));
      if (d > 32767)  begin d = 32767;  v = 1'b1; end
      if (d < -32768) begin d = -32768; v = 1'b1; end
      r = d[15:0];
      n = r[15];
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [3:0] an, bn;
        an = a[i*4 +: 4];
        bn = b[i*4 +: 4];
        d = int'($signed(an)) - int'($signed(bn));
        if (d > 7)  d = 7;
        if (d < -8) d = -8;
        r[i*4 +: 4] = d[3:0];
      end
    end
    z = (r == 16'h0000);
    if (!FLAGS) begin z = 1'b0; n = 1'b0; v = 1'b0; end
    return {z, n, v, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle scoreboard ----------------
  // ph counts cycles since accept: 0 idle, 1..4 busy, 5 done.
  int          ph = 0;
  logic [15:0] la = '0, lb = '0;
  logic        lm = 1'b0;
  logic [18:0] held = '0;
  logic [18:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0;
      held = '0;
      exp_q.delete();
    end else if (ph == 0) begin
      if (ifc.start) begin
        ph = 1;
        la = ifc.A;
        lb = ifc.B;
        lm = ifc.mode;
        exp_q.push_back(model(ifc.A, ifc.B, ifc.mode));
      end
    end else if (ph == 4) begin
      ph = 5;
      if (exp_q.size() > 0) held = exp_q.pop_front();
    end else if (ph == 5) begin
      ph = 0;
    end else begin
      ph++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_done", 32'(ifc.done), 32'd0);
      chk("rst_result", 32'(ifc.result), 32'd0);
      chk("rst_flags", 32'({ifc.Z, ifc.N, ifc.V}), 32'd0);
    end else begin
      chk("busy", 32'(ifc.busy), 32'(ph >= 1 && ph <= 4));
      chk("done", 32'(ifc.done), 32'(ph == 5));
      if (ph == 0 || ph == 5) begin
        chk("result", 32'(ifc.result), 32'(held[15:0]));
        chk("flags", 32'({ifc.Z, ifc.N, ifc.V}), 32'(held[18:16]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic m);
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.A = a;
    ifc.B = b;
    ifc.mode = m;
    t_acc = cyc;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
  endtask

  // Waits (bounded) for done; lat is cycles from the request cycle, -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.busy) busy_cnt++;
      if (ifc.done) begin
        lat = cyc - t_acc;
        break;
      end
    end
  endtask

  task automatic chk_out(input string name, input logic [15:0] r, input logic z, input logic n, input logic v);
    chk({name, "_res"}, 32'(ifc.result), 32'(r));
    chk({name, "_znv"}, 32'({ifc.Z, ifc.N, ifc.V}), 32'({z & FLAGS, n & FLAGS, v & FLAGS}));
  endtask

  task automatic garbage();
    ifc.start = 1'($urandom_range(0, 1));
    ifc.A = 16'($urandom);
    ifc.B = 16'($urandom);
    ifc.mode = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bc;
    logic [18:0] m;
    ifc.start = 1'b0;
    ifc.mode = MODE_SUB;
    ifc.A = '0;
    ifc.B = '0;

    // Model pinned to hand-computed values.
    m = model(16'h0005, 16'h0003, MODE_SUB);
    chk("pin_sub", 32'(m), 32'({FLAGS & 1'b0, 1'b0, 1'b0, 16'h0002}));
    m = model(16'h7830, 16'hF123, MODE_PSUBSB);
    chk("pin_psub", 32'(m[15:0]), 32'h781D);
    m = model(16'h7FFF, 16'hFFFF, MODE_SUB);
    chk("pin_pos_sat", 32'(m), 32'({1'b0, 1'b0, FLAGS, 16'h7FFF}));
    m = model(16'h8000, 16'h0001, MODE_SUB);
    chk("pin_neg_sat", 32'(m), 32'({1'b0, FLAGS, FLAGS, 16'h8000}));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));

    // 5 - 3
    issue(16'h0005, 16'h0003, MODE_SUB);
    wait_done(lat, bc);
    chk("lat_5m3", 32'(lat), 32'd5);
    chk("busy_cycles", 32'(bc), 32'd4);
    chk_out("sub_5m3", 16'h0002, 1'b0, 1'b0, 1'b0);

    // Positive and negative saturation.
    issue(16'h7FFF, 16'hFFFF, MODE_SUB);
    wait_done(lat, bc);
    chk("lat_pos", 32'(lat), 32'd5);
    chk_out("sat_pos", 16'h7FFF, 1'b0, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, MODE_SUB);
    wait_done(lat, bc);
    chk_out("sat_neg", 16'h8000, 1'b0, 1'b1, 1'b1);

    // Packed lanes.
    issue(16'h7830, 16'hF123, MODE_PSUBSB);
    wait_done(lat, bc);
    chk("lat_psub", 32'(lat), 32'd5);
    chk_out("psubsb", 16'h781D, 1'b0, 1'b0, 1'b0);

    // Zero result with an ignored start at T+2.
    issue(16'h1234, 16'h1234, MODE_SUB);
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.A = 16'hFFFF;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    wait_done(lat, bc);
    chk("lat_zero", 32'(lat), 32'd5);
    chk_out("zero", 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("no_requeue", 32'(ifc.busy), 32'd0);

    // Reset mid-operation at T+3.
    issue(16'h00F0, 16'h0001, MODE_SUB);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_rst_result", 32'(ifc.result), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(16'h00F0, 16'h0001, MODE_SUB);
    wait_done(lat, bc);
    chk("lat_after_rst", 32'(lat), 32'd5);
    chk_out("after_rst", 16'h00EF, 1'b0, 1'b0, 1'b0);

    // Randomized operations with junk on the inputs while busy.
    for (int k = 0; k < 60; k++) begin
      logic [15:0] ra, rb;
      logic        rm;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 4 == 0) rb = ra ^ 16'($urandom_range(0, 1) << 15);
      rm = 1'($urandom_range(0, 1));
      issue(ra, rb, rm);
      garbage();
      repeat (3) begin
        @(posedge clk);
        #1 garbage();
      end
      @(posedge clk);
      #1 ifc.start = 1'b0;
      @(negedge clk);
      chk("rand_done", 32'(ifc.done), 32'd1);
      m = model(ra, rb, rm);
      chk("rand_res", 32'(ifc.result), 32'(m[15:0]));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
